alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised W-bit sequential ALU, the successor to the 4-bit combinational ALU. It registers operands, performs the logic and arithmetic ops (NOT, AND, OR, XOR, XNOR, ADD, SUB) in one cycle, and adds a multi-cycle unsigned shift-add multiply with a start/busy/done handshake. It sits between the operand register file and the result/flag registers of the datapath and produces carry, overflow, zero and negative flags.

## Interface
- W, 4, operand width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  opcode: 0 NOT a, 1 AND, 2 OR, 3 XOR, 4 XNOR, 5 ADD, 6 SUB (a-b), 7 MUL (unsigned)
- a  in  W  operand A
- b  in  W  operand B
- busy  out  1  high while a multiply is in progress
- done  out  1  one-cycle pulse when y, y_hi and the flags update
- y  out  W  result; low half of the product for MUL
- y_hi  out  W  high half of the product for MUL; 0 for all other ops
- c  out  1  carry / no-borrow / product-overflow flag
- v  out  1  signed overflow flag
- z  out  1  zero flag
- n  out  1  negative flag

## Operation
- States: IDLE, MUL. Reset forces IDLE.
- IDLE with start=1 and op 0..6: result and flags are computed from a, b and op at that edge and registered. done=1 for the following cycle. State stays IDLE.
- IDLE with start=1 and op=7: a, b and op are latched, the accumulator and counter are cleared, and the state goes to MUL. busy=1.
- MUL: each edge examines one multiplier bit, LSB first. If the bit is set, the multiplicand is added into the upper half of the 2W accumulator, then the accumulator shifts right one bit (W+1-bit adder keeps the carry). After W edges: {y_hi,y} = product, state returns to IDLE, busy=0, done=1.
- start while busy: ignored. No queuing.
- Arithmetic: SUB = a + ~b + 1 computed on W+1 bits.
- c:
  - ADD: carry out.
  - SUB: carry out, so 1 means no borrow (a>=b unsigned).
  - MUL: 1 iff y_hi != 0.
  - Logic ops: 0.
- v:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
  - Logic ops and MUL: 0.
- z: 1 iff y==0, or iff {y_hi,y}==0 for MUL.
- n: y[W-1] for ops 0..6; y_hi[W-1] for MUL.
- y, y_hi and the flags hold their values between done pulses. They change only on the edge that raises done.
- Reset (asynchronous, any time, including mid-multiply): state IDLE. busy, done, y, y_hi, c, v, z, n all 0. Any partial product is discarded. The first start after reset release is accepted normally.

## Timing
- Single-cycle ops: start sampled at edge 0 → done high and results valid in cycle 0+1. Latency 1, throughput one op per cycle (back-to-back start accepted).
- MUL: start sampled at edge 0 → busy high for exactly W cycles (after edges 0..W-1) → done high and product valid in the cycle after edge W. Latency W+1 edges from the start sample to done falling.
- start asserted in the done cycle of a MUL: accepted, because the state is IDLE.
- done is never high for two consecutive cycles except on back-to-back single-cycle ops, each of which produces its own pulse.
- busy and done are never high simultaneously.

## Test plan
- Reset then ADD, W=4, a=7, b=1 → next cycle done=1, y=8, c=0, v=1, n=1, z=0.
- SUB, a=3, b=5 → y=0xE, c=0, v=0, n=1. Then SUB, a=5, b=5 → y=0, z=1, c=1.
- XNOR, a=0xA, b=0x6 → y=0x3, c=0, v=0. Then NOT, a=0x0 → y=0xF, n=1.
- MUL, a=0xF, b=0xF → busy high 4 cycles, done at the 5th edge, {y_hi,y}=0xE1, c=1, z=0. start pulses with op=ADD during busy are ignored (no extra done).
- MUL, a=0x0, b=0x9 → product 0, z=1, c=0. Then ADD, a=1, b=1 issued in the done cycle → accepted, y=2 one cycle later.
- Reset asserted mid-MUL (cycle 2 of busy) → all outputs 0 immediately. After release, MUL 3×5 → {y_hi,y}=0x0F.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - W-bit sequential ALU: single-cycle logic/add/sub plus shift-add unsigned multiply
module alu_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] y,
    output logic [W-1:0] y_hi,
    output logic         c,
    output logic         v,
    output logic         z,
    output logic         n
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     mcand;
    logic [2*W-1:0]   acc;
    logic [CW-1:0]    cnt;

    logic [W:0]       add_sum;
    logic [W:0]       sub_diff;
    logic [W-1:0]     alu_y;
    logic             alu_c;
    logic             alu_v;

    logic [W:0]       mul_sum;
    logic [2*W-1:0]   acc_step;
    logic             mul_last;

    assign add_sum  = {1'b0, a} + {1'b0, b};
    assign sub_diff = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            3'd0: alu_y = ~a;
            3'd1: alu_y = a & b;
            3'd2: alu_y = a | b;
            3'd3: alu_y = a ^ b;
            3'd4: alu_y = ~(a ^ b);
            3'd5: begin
                alu_y = add_sum[W-1:0];
                alu_c = add_sum[W];
                alu_v = (a[W-1] == b[W-1]) && (add_sum[W-1] != a[W-1]);
            end
            3'd6: begin
                alu_y = sub_diff[W-1:0];
                alu_c = sub_diff[W];
                alu_v = (a[W-1] != b[W-1]) && (sub_diff[W-1] != a[W-1]);
            end
            default: alu_y = '0;
        endcase
    end

    // The low half of acc starts out holding the multiplier, so acc[0] is always the bit under test.
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    assign acc_step = {mul_sum, acc[W-1:1]};
    assign mul_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start && op == OP_MUL) state_next = S_MUL;
            S_MUL:  if (mul_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_MUL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            y     <= '0;
            y_hi  <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
            z     <= 1'b0;
            n     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand <= a;
                            acc   <= {{W{1'b0}}, b};
                            cnt   <= '0;
                        end else begin
                            y    <= alu_y;
                            y_hi <= '0;
                            c    <= alu_c;
                            v    <= alu_v;
                            z    <= (alu_y == '0);
                            n    <= alu_y[W-1];
                            done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                    if (mul_last) begin
                        y    <= acc_step[W-1:0];
                        y_hi <= acc_step[2*W-1:W];
                        c    <= |acc_step[2*W-1:W];
                        v    <= 1'b0;
                        z    <= (acc_step == '0);
                        n    <= acc_step[2*W-1];
                        done <= 1'b1;
                    end
                end
                default: done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

    localparam int     W    = 4;
    localparam longint MASK = (longint'(1) << W) - 1;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic         c;
    logic         v;
    logic         z;
    logic         n;

    always #5 clk = ~clk;

    alu_seq #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .y_hi  (y_hi),
        .c     (c),
        .v     (v),
        .z     (z),
        .n     (n)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit armed    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        longint y;
        longint yh;
        bit     c;
        bit     v;
        bit     z;
        bit     n;
    } res_t;

    function automatic longint sgn(input longint x);
        return (((x >> (W - 1)) & 1) != 0) ? x - (longint'(1) << W) : x;
    endfunction

    function automatic res_t zero_res();
        res_t r;
        r.y = 0; r.yh = 0; r.c = 0; r.v = 0; r.z = 0; r.n = 0;
        return r;
    endfunction

    function automatic res_t ref_op(input int o, input longint x, input longint q);
        res_t   r;
        longint s;
        r = zero_res();
        case (o)
            0: r.y = ~x & MASK;
            1: r.y = x & q;
            2: r.y = x | q;
            3: r.y = x ^ q;
            4: r.y = ~(x ^ q) & MASK;
            5: begin
                s   = x + q;
                r.c = (s > MASK);
                r.y = s & MASK;
                s   = sgn(x) + sgn(q);
                r.v = (s > SMAX) || (s < SMIN);
            end
            6: begin
                r.c = (x >= q);
                r.y = (x - q) & MASK;
                s   = sgn(x) - sgn(q);
                r.v = (s > SMAX) || (s < SMIN);
            end
            default: begin
                s    = x * q;
                r.y  = s & MASK;
                r.yh = s >> W;
                r.c  = (r.yh != 0);
            end
        endcase
        r.z = (r.y == 0) && (r.yh == 0);
        r.n = (o == 7) ? (((r.yh >> (W - 1)) & 1) != 0) : (((r.y >> (W - 1)) & 1) != 0);
        return r;
    endfunction

    // Reference model: a multiply is just a countdown of W cycles with its answer held aside.
    res_t m_res;
    res_t pend;
    bit   m_done;
    bit   m_busy;
    int   mul_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_res    <= zero_res();
            pend     <= zero_res();
            m_done   <= 0;
            m_busy   <= 0;
            mul_left <= 0;
        end else if (mul_left > 0) begin
            mul_left <= mul_left - 1;
            m_busy   <= (mul_left > 1);
            m_done   <= (mul_left == 1);
            if (mul_left == 1) m_res <= pend;
        end else if (start && op == 3'd7) begin
            pend     <= ref_op(7, longint'(a), longint'(b));
            mul_left <= W;
            m_busy   <= 1;
            m_done   <= 0;
        end else if (start) begin
            m_res  <= ref_op(int'(op), longint'(a), longint'(b));
            m_done <= 1;
            m_busy <= 0;
        end else begin
            m_done <= 0;
            m_busy <= 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("y",    64'(y),    64'(m_res.y));
            check("y_hi", 64'(y_hi), 64'(m_res.yh));
            check("c",    64'(c),    64'(m_res.c));
            check("v",    64'(v),    64'(m_res.v));
            check("z",    64'(z),    64'(m_res.z));
            check("n",    64'(n),    64'(m_res.n));
        end
    end

    task automatic cyc(input bit st, input int o, input longint x, input longint q, input bit rst = 0);
        #1;
        reset = rst;
        start = st;
        op    = o[2:0];
        a     = x[W-1:0];
        b     = q[W-1:0];
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        armed = 1;
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_y",    64'(y),    0);
        check("rst_flags", 64'({c, v, z, n}), 0);

        cyc(0, 0, 0, 0);
        cyc(1, 5, 7, 1);
        check("add_done", 64'(done), 1);
        check("add_y",    64'(y), 8);
        check("add_cvzn", 64'({c, v, z, n}), 64'b0101);

        cyc(1, 6, 3, 5);
        check("sub35_y",   64'(y), 'hE);
        check("sub35_cvn", 64'({c, v, n}), 64'b001);
        cyc(1, 6, 5, 5);
        check("sub55_y",  64'(y), 0);
        check("sub55_cz", 64'({c, z}), 64'b11);

        cyc(1, 4, 'hA, 'h6);
        check("xnor_y",  64'(y), 3);
        check("xnor_cv", 64'({c, v}), 0);
        cyc(1, 0, 0, 0);
        check("not_y", 64'(y), 'hF);
        check("not_n", 64'(n), 1);

        cyc(1, 7, 'hF, 'hF);
        check("mulff_busy0", 64'({busy, done}), 64'b10);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5, 1, 2);
            check("mulff_busy", 64'({busy, done}), 64'b10);
        end
        cyc(0, 0, 0, 0);
        check("mulff_done", 64'({busy, done}), 64'b01);
        check("mulff_prod", 64'({y_hi, y}), 'hE1);
        check("mulff_cz",   64'({c, z}), 64'b10);
        cyc(0, 0, 0, 0);
        check("mulff_pulse", 64'(done), 0);

        cyc(1, 7, 0, 9);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("mul0_done", 64'(done), 1);
        check("mul0_prod", 64'({y_hi, y}), 0);
        check("mul0_zc",   64'({z, c}), 64'b10);
        cyc(1, 5, 1, 1);
        check("add_after_mul", 64'({done, y}), 64'h12);

        cyc(0, 0, 0, 0);
        cyc(1, 7, 3, 5);
        cyc(0, 0, 0, 0);
        check("midmul_busy", 64'(busy), 1);
        #1 reset = 1;
        #1;
        check("async_rst_out", 64'({busy, done, y, y_hi, c, v, z, n}), 0);
        @(negedge clk);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 7, 3, 5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("mul35_done", 64'(done), 1);
        check("mul35_prod", 64'({y_hi, y}), 'h0F);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 3) != 0, int'($urandom % 8), longint'($urandom) & MASK,
                longint'($urandom) & MASK, ($urandom % 250) == 0);
        end
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < W + 2; i++) cyc(0, 0, 0, 0);
        armed = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
